// File: rtl/sr_imem_loader.sv
// Instruction memory with a byte-stream program loader.
// Optional SR_IMEM_CHECKSUM_EN builds a running sum of written words.
module sr_imem_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           imAddr,
  output logic [31:0]           imData,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  output logic                  ld_ready,
  input  logic                  ld_done,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic [31:0]           ld_csum
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_PTR = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t              state, state_n;
  logic [ADDR_WIDTH:0] wr_ptr, ptr_n;
  logic [1:0]          bcnt, bcnt_n;
  logic [23:0]         asm_q, asm_n;
  logic                ovf, ovf_n;
  logic                full;
  logic                we;
  logic [31:0]         wdata;
  logic [31:0]         mem [DEPTH];

  assign full = (wr_ptr == FULL_PTR);

  // Next-state, byte assembly and memory write request.
  always_comb begin
    state_n  = state;
    ptr_n    = wr_ptr;
    bcnt_n   = bcnt;
    asm_n    = asm_q;
    ovf_n    = ovf;
    we       = 1'b0;
    wdata    = 32'h0;
    ld_ready = (state == LOAD);
    unique case (state)
      IDLE: begin
        if (ld_start) begin
          state_n = LOAD;
          ptr_n   = '0;
          bcnt_n  = '0;
          asm_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          ptr_n  = '0;
          bcnt_n = '0;
          asm_n  = '0;
          ovf_n  = 1'b0;
        end else begin
          if (ld_valid) begin
            if (full) begin
              ovf_n = 1'b1;
            end else if (bcnt == 2'd3) begin
              we     = 1'b1;
              wdata  = {ld_byte, asm_q};
              ptr_n  = wr_ptr + 1'b1;
              bcnt_n = '0;
              asm_n  = '0;
            end else begin
              asm_n[{bcnt, 3'b000} +: 8] = ld_byte;
              bcnt_n = bcnt + 1'b1;
            end
          end
          if (ld_done) begin
            state_n = (bcnt_n == 2'd0) ? IDLE : FLUSH;
          end
        end
      end
      FLUSH: begin
        if (ld_start) begin
          state_n = LOAD;
          ptr_n   = '0;
          bcnt_n  = '0;
          asm_n   = '0;
          ovf_n   = 1'b0;
        end else begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            we    = 1'b1;
            wdata = {8'h00, asm_q};
            ptr_n = wr_ptr + 1'b1;
          end
          bcnt_n  = '0;
          asm_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      bcnt   <= '0;
      asm_q  <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ptr <= ptr_n;
      bcnt   <= bcnt_n;
      asm_q  <= asm_n;
      ovf    <= ovf_n;
    end
  end

  // Word write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

`ifdef SR_IMEM_CHECKSUM_EN
  logic [31:0] csum;

  // Sum of every word committed to memory this session.
  always_ff @(posedge clk) begin
    if (rst || ld_start) begin
      csum <= '0;
    end else if (we) begin
      csum <= csum + wdata;
    end
  end

  assign ld_csum = csum;
`else
  assign ld_csum = 32'h0;
`endif

  assign cpu_hold   = rst | (state != IDLE);
  assign word_count = wr_ptr;
  assign overflow   = ovf;

  // Zero-latency fetch; NOP while the core is held.
  always_comb begin
    imData = 32'h0;
    if (cpu_hold) begin
      imData = NOP_WORD;
    end else if (imAddr[31:ADDR_WIDTH] == '0) begin
      imData = mem[imAddr[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_sr_imem_loader.sv
// Scoreboard bench for sr_imem_loader.
// Drives a 64-word and a 4-word instance with the same stream.
module tb_sr_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int K_DATA = 0;
  localparam int K_RDY  = 1;
  localparam int K_HOLD = 2;
  localparam int K_WC   = 3;
  localparam int K_OVF  = 4;
  localparam int K_CSUM = 5;

`ifdef SR_IMEM_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    logic [31:0] exp;
    int          due;
  } chk_t;

  logic        clk;
  logic        rst;
  logic [31:0] imAddr;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_done;

  logic [31:0] dat6, dat2, cs6, cs2;
  logic        rdy6, rdy2, hold6, hold2, ovf6, ovf2;
  logic [6:0]  wc6;
  logic [2:0]  wc2;

  chk_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  sr_imem_loader #(.ADDR_WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(dat6),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(rdy6), .ld_done(ld_done), .cpu_hold(hold6),
    .word_count(wc6), .overflow(ovf6), .ld_csum(cs6)
  );

  sr_imem_loader #(.ADDR_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(dat2),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(rdy2), .ld_done(ld_done), .cpu_hold(hold2),
    .word_count(wc2), .overflow(ovf2), .ld_csum(cs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] obs(int d, int k);
    logic [31:0] v;
    v = 32'h0;
    case (k)
      K_DATA: v = d ? dat2 : dat6;
      K_RDY:  v = {31'h0, d ? rdy2 : rdy6};
      K_HOLD: v = {31'h0, d ? hold2 : hold6};
      K_WC:   v = d ? {29'h0, wc2} : {25'h0, wc6};
      K_OVF:  v = {31'h0, d ? ovf2 : ovf6};
      K_CSUM: v = d ? cs2 : cs6;
      default: v = 32'hdead_beef;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] csx(logic [31:0] x);
    return CS ? x : 32'h0;
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    while (q.size() > 0 && q[0].due <= cyc) begin
      c = q.pop_front();
      got = obs(c.dut, c.kind);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL %s dut%0d got %h want %h",
                 c.name, c.dut, got, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string n, int d, int k, logic [31:0] e);
    chk_t c;
    c.name = n;
    c.dut  = d;
    c.kind = k;
    c.exp  = e;
    c.due  = cyc;
    q.push_back(c);
  endtask

  task automatic put(logic v, logic [7:0] b, logic dn, logic st);
    ld_valid = v;
    ld_byte  = b;
    ld_done  = dn;
    ld_start = st;
  endtask

  task automatic send(logic [7:0] b);
    put(1'b1, b, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    imAddr = 32'h0;
    put(1'b0, 8'h00, 1'b0, 1'b0);

    step();
    push("rst_hold", 0, K_HOLD, 32'h1);
    push("rst_nop",  0, K_DATA, NOP);
    push("rst_wc",   0, K_WC,   32'h0);
    push("rst_ovf",  0, K_OVF,  32'h0);
    push("rst_rdy",  0, K_RDY,  32'h0);
    push("rst_csum", 0, K_CSUM, 32'h0);
    step();
    rst = 1'b0;
    push("idle_hold", 0, K_HOLD, 32'h0);
    push("idle_rdy",  0, K_RDY,  32'h0);

    // Full word load
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("load_rdy", 0, K_RDY,  32'h1);
    push("load_nop", 0, K_DATA, NOP);
    send(8'h13);
    send(8'h05);
    send(8'h10);
    send(8'h00);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    push("done_hold", 0, K_HOLD, 32'h1);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("w_hold", 0, K_HOLD, 32'h0);
    push("w_wc",   0, K_WC,   32'h1);
    push("w_data", 0, K_DATA, 32'h0010_0513);
    push("w_csum", 0, K_CSUM, csx(32'h0010_0513));
    step();
    imAddr = 32'd64;
    push("range64", 0, K_DATA, 32'h0);
    step();
    imAddr = 32'h0;

    // Partial word flush
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    send(8'hAA);
    send(8'hBB);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("fl_rdy",  0, K_RDY,  32'h0);
    push("fl_hold", 0, K_HOLD, 32'h1);
    step();
    push("fl_data", 0, K_DATA, 32'h0000_BBAA);
    push("fl_wc",   0, K_WC,   32'h1);
    push("fl_csum", 0, K_CSUM, csx(32'h0000_BBAA));

    // Done with the fourth byte: no flush cycle
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    put(1'b1, 8'hEF, 1'b1, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("sc_hold", 0, K_HOLD, 32'h0);
    push("sc_rdy",  0, K_RDY,  32'h0);
    push("sc_data", 0, K_DATA, 32'hEFBE_ADDE);
    push("sc_wc",   0, K_WC,   32'h1);

    // 17 bytes: 4-word instance overflows, 64-word one flushes
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 17; i++) send(8'(i));
    put(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("of_hold2", 1, K_HOLD, 32'h0);
    push("of_hold6", 0, K_HOLD, 32'h1);
    push("of_rdy6",  0, K_RDY,  32'h0);
    step();
    imAddr = 32'd3;
    push("of_wc2",   1, K_WC,   32'h4);
    push("of_ovf2",  1, K_OVF,  32'h1);
    push("of_csum2", 1, K_CSUM, csx(32'h2420_1C18));
    push("of_data2", 1, K_DATA, 32'h0F0E_0D0C);
    push("of_wc6",   0, K_WC,   32'h5);
    push("of_ovf6",  0, K_OVF,  32'h0);
    push("of_csum6", 0, K_CSUM, csx(32'h2420_1C28));
    step();
    imAddr = 32'd4;
    push("of_rng2",  1, K_DATA, 32'h0);
    push("of_data6", 0, K_DATA, 32'h0000_0010);
    step();
    imAddr = 32'h0;

    // Restart mid-word
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("rs_ovf2", 1, K_OVF, 32'h0);
    send(8'h77);
    send(8'h88);
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0, 1'b0);
    push("rs_data", 0, K_DATA, 32'h0403_0201);
    push("rs_wc",   0, K_WC,   32'h1);
    push("rs_csum", 0, K_CSUM, csx(32'h0403_0201));

    // Reset in the middle of a session
    put(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    send(8'h55);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    push("mr_hold", 0, K_HOLD, 32'h1);
    push("mr_nop",  0, K_DATA, NOP);
    step();
    rst = 1'b0;
    push("ar_hold", 0, K_HOLD, 32'h0);
    push("ar_rdy",  0, K_RDY,  32'h0);
    push("ar_ovf",  0, K_OVF,  32'h0);
    push("ar_wc",   0, K_WC,   32'h0);
    push("ar_data", 0, K_DATA, 32'h0403_0201);
    push("ar_csum", 0, K_CSUM, 32'h0);
    push("ar_ovf2", 1, K_OVF,  32'h0);
    step();

    for (int i = 0; i < 4 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_imem_loader.md
Name: sr_imem_loader

Overview:
- Instruction-memory responder for the CPU fetch port. Answers word-address fetches on imAddr with imData in the same cycle, which is what a single-cycle core requires.
- Also the program-load path: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words into memory.
- Holds the CPU in reset while a load is in progress.
- Sits between the CPU's fetch interface and a host or debug byte source.

Parameters:
- ADDR_WIDTH, 6, word-address bits; DEPTH = 2**ADDR_WIDTH words.
- NOP_WORD, 32'h00000013, word returned on imData while cpu_hold=1 (addi x0,x0,0).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- imAddr  input  32  fetch word address (pc >> 2).
- imData  output  32  fetch data, combinational.
- ld_start  input  1  pulse: begin load session, write pointer to 0.
- ld_valid  input  1  ld_byte is valid this cycle.
- ld_byte  input  8  load data byte.
- ld_ready  output  1  loader accepts a byte this cycle.
- ld_done  input  1  pulse: end load session.
- cpu_hold  output  1  high = keep CPU in reset.
- word_count  output  ADDR_WIDTH+1  words written in the current or last session.
- overflow  output  1  sticky: bytes were dropped because memory was full.
- ld_csum  output  32  running checksum (see Optional Feature).

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - rst is synchronous and active-high.
  - rst clears state to IDLE and clears the write pointer, byte counter, assembly register, overflow and ld_csum.
  - Memory contents are not cleared by rst.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - ld_ready=0.
  - ld_start -> LOAD, clearing the write pointer, byte count, overflow and ld_csum.
  - ld_valid and ld_done are ignored.
- LOAD:
  - ld_ready=1.
  - A byte is accepted on a cycle with ld_valid & ld_ready.
  - Byte k (k = 0..3 within a word) lands in bits [8k+7:8k].
  - On acceptance of byte 3, the word {ld_byte, asm[23:0]} is written at mem[wr_ptr] on that same edge; wr_ptr increments and the byte count wraps to 0.
  - A fetch of that address in the following cycle sees the new word.
- Full memory:
  - When wr_ptr == DEPTH, accepted bytes are dropped and overflow sets (sticky until the next ld_start).
  - ld_ready stays 1, so the source is never stalled.
- ld_done in LOAD:
  - If a byte is accepted in the same cycle, it is counted first.
  - If the byte count is 0 after that: -> IDLE directly.
  - Otherwise: -> FLUSH.
- FLUSH (1 cycle):
  - ld_ready=0.
  - Writes the partial word, zero-padding the missing upper bytes, unless memory is full (in which case overflow sets).
  - wr_ptr increments, then -> IDLE.
- ld_start while in LOAD or FLUSH: restart the session; the pending partial word is discarded.
- ld_start and ld_done in the same cycle: ld_start wins.
- cpu_hold = rst | (state != IDLE), combinational. It is 1 during reset.
- Fetch path:
  - imData = NOP_WORD when cpu_hold=1.
  - Otherwise imData = mem[imAddr[ADDR_WIDTH-1:0]] if imAddr[31:ADDR_WIDTH]==0, else 32'h0.
  - Zero read latency.
- word_count = wr_ptr. It saturates at DEPTH and holds its value in IDLE until the next ld_start.
- Reset mid-session: the session is aborted; words already written remain in memory; cpu_hold stays 1 for the reset cycle, then goes 0 in IDLE.

Optional Feature:
- Macro: SR_IMEM_CHECKSUM_EN.
- Defined:
  - ld_csum is a 32-bit modulo-2^32 sum of every word actually written to memory, including a zero-padded flush word.
  - It is cleared on rst and on ld_start.
  - Dropped bytes are not summed.
- Undefined: ld_csum is tied to 32'h0 and no adder is built.

Test Plan:
- Word load: rst, then ld_start, then bytes 13,05,10,00 in consecutive cycles, then ld_done.
  - Required: word_count=1; cpu_hold falls the cycle after ld_done; imAddr=0 gives imData=32'h00100513; ld_csum=32'h00100513 with the macro, 0 without.
- Partial flush: ld_start, bytes AA,BB, then ld_done.
  - Required: one FLUSH cycle with ld_ready=0; mem[0]=32'h0000BBAA; word_count=1.
- Same-cycle done: ld_done in the same cycle as the 4th byte EF (after DE,AD,BE).
  - Required: direct LOAD->IDLE with no FLUSH cycle; mem[0]=32'hEFBEADDE.
- Overflow: ADDR_WIDTH=2; load 17 bytes.
  - Required: word_count=4; overflow=1; mem[3] holds bytes 12..15; byte 16 dropped; ld_csum = sum of the 4 written words.
- Hold and range: during LOAD, imAddr=0 gives 32'h00000013. After load, imAddr=64 with ADDR_WIDTH=6 gives 32'h0.
- Restart and reset: ld_start after 2 bytes of a word, then bytes 01,02,03,04.
  - Required: mem[0]=32'h04030201.
  - Then rst asserted mid-session: state IDLE, cpu_hold=1 for that cycle then 0, memory retained, overflow=0.
